pkt_rx_checker: RTL and testbench

- Synthesizable receive-side DUT for the OOP testbench; the transaction generator feeds it through the driver.
- Accepts a fixed-format packet as a stream of words under a valid/ready handshake: src, dst, N_DATA data words, then crc.
- Recomputes the CRC as the XOR of src, dst and all data words, and reports one result per packet.
- Keeps saturating counters of good packets, bad-CRC packets and framing errors for scoreboard cross-checking.

---
 rtl/pkt_rx_checker.sv | 163 ++++++++++++++++
 tb/tb_pkt_rx_checker.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_rx_checker.sv
// pkt_rx_checker
// Receive-side packet checker. Takes a fixed-format packet as a word stream:
// src (marked by in_sop), dst, N_DATA data words, then crc. The expected crc
// is the XOR of src, dst and every data word. One result is reported per
// complete packet. Saturating counters record good packets, bad-crc packets
// and framing errors.
//
// Ports:
//   clk, rst         single rising-edge clock, synchronous active-high reset
//   in_valid/in_ready/in_sop/in_data   word input under valid/ready
//   out_valid/out_ready                result handshake
//   out_src/out_dst/out_crc_ok         result of the last completed packet
//   good_cnt/bad_cnt/frame_err_cnt     saturating statistics counters
module pkt_rx_checker #(
  parameter int DW     = 32,
  parameter int N_DATA = 8,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sop,
  input  logic [DW-1:0]    in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_src,
  output logic [DW-1:0]    out_dst,
  output logic             out_crc_ok,
  output logic [CNT_W-1:0] good_cnt,
  output logic [CNT_W-1:0] bad_cnt,
  output logic [CNT_W-1:0] frame_err_cnt
);

  localparam int IDX_W = (N_DATA > 1) ? $clog2(N_DATA) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DATA - 1);

  typedef enum logic [2:0] {
    S_SRC,
    S_DST,
    S_DATA,
    S_CRC,
    S_OUT
  } state_t;

  state_t            state_reg;
  logic [DW-1:0]     acc_reg;
  logic [DW-1:0]     cur_src_reg;
  logic [DW-1:0]     cur_dst_reg;
  logic [IDX_W-1:0]  idx_reg;
  logic [DW-1:0]     out_src_reg;
  logic [DW-1:0]     out_dst_reg;
  logic              out_crc_ok_reg;
  logic              out_valid_reg;

  logic              accept;
  logic              in_body;
  logic [2:0]        cnt_inc;  // [0] good, [1] bad, [2] framing error

  assign in_ready = (state_reg != S_OUT);
  assign accept   = in_valid && in_ready;
  assign in_body  = (state_reg == S_DST) || (state_reg == S_DATA) || (state_reg == S_CRC);

  assign out_valid  = out_valid_reg;
  assign out_src    = out_src_reg;
  assign out_dst    = out_dst_reg;
  assign out_crc_ok = out_crc_ok_reg;

  // Counter events. A crc word carrying sop is an abort, so it never counts
  // as good or bad.
  always_comb begin
    cnt_inc    = 3'b000;
    cnt_inc[0] = accept && (state_reg == S_CRC) && !in_sop && (acc_reg == in_data);
    cnt_inc[1] = accept && (state_reg == S_CRC) && !in_sop && (acc_reg != in_data);
    cnt_inc[2] = accept && (((state_reg == S_SRC) && !in_sop) || (in_body && in_sop));
  end

  logic [CNT_W-1:0] cnt_reg [3];

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_reg[gi] <= '0;
        end else if (cnt_inc[gi] && (cnt_reg[gi] != {CNT_W{1'b1}})) begin
          cnt_reg[gi] <= cnt_reg[gi] + 1'b1;
        end
      end
    end
  endgenerate

  assign good_cnt      = cnt_reg[0];
  assign bad_cnt       = cnt_reg[1];
  assign frame_err_cnt = cnt_reg[2];

  // Packet-path FSM. src/dst are captured into working registers and only
  // copied to the result outputs when a packet completes, so the visible
  // result holds until the next packet finishes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= S_SRC;
      acc_reg        <= '0;
      cur_src_reg    <= '0;
      cur_dst_reg    <= '0;
      idx_reg        <= '0;
      out_src_reg    <= '0;
      out_dst_reg    <= '0;
      out_crc_ok_reg <= 1'b0;
      out_valid_reg  <= 1'b0;
    end else begin
      case (state_reg)
        S_SRC: begin
          if (accept && in_sop) begin
            cur_src_reg <= in_data;
            acc_reg     <= in_data;
            state_reg   <= S_DST;
          end
        end

        S_DST, S_DATA, S_CRC: begin
          if (accept) begin
            if (in_sop) begin
              // Abort: restart with this word as the new src.
              cur_src_reg <= in_data;
              acc_reg     <= in_data;
              state_reg   <= S_DST;
            end else if (state_reg == S_DST) begin
              cur_dst_reg <= in_data;
              acc_reg     <= acc_reg ^ in_data;
              idx_reg     <= '0;
              state_reg   <= S_DATA;
            end else if (state_reg == S_DATA) begin
              acc_reg <= acc_reg ^ in_data;
              idx_reg <= idx_reg + 1'b1;
              if (idx_reg == LAST_IDX) begin
                state_reg <= S_CRC;
              end
            end else begin
              out_src_reg    <= cur_src_reg;
              out_dst_reg    <= cur_dst_reg;
              out_crc_ok_reg <= (acc_reg == in_data);
              out_valid_reg  <= 1'b1;
              state_reg      <= S_OUT;
            end
          end
        end

        S_OUT: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            state_reg     <= S_SRC;
          end
        end

        default: begin
          state_reg     <= S_SRC;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pkt_rx_checker.sv
// Testbench for pkt_rx_checker. A driver issues directed packets; expected
// results are pushed into a queue when a packet is issued, and a monitor pops
// and compares on every result handshake. A second instance built with
// CNT_W=2 exercises counter saturation.
module tb_pkt_rx_checker;

  localparam int DW = 32;
  localparam int N  = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          drv_valid;
  logic          drv_sop;
  logic [DW-1:0] drv_data;
  logic          drv_ready;
  logic          sel_sat;
  logic          out_ready;

  // main instance
  logic          in_valid, in_ready, out_valid, out_crc_ok;
  logic [DW-1:0] out_src, out_dst;
  logic [15:0]   good_cnt, bad_cnt, frame_err_cnt;

  // saturation instance
  logic          s_in_valid, s_in_ready, s_out_valid, s_out_crc_ok;
  logic [DW-1:0] s_out_src, s_out_dst;
  logic [1:0]    s_good_cnt, s_bad_cnt, s_frame_err_cnt;

  assign in_valid   = drv_valid && !sel_sat;
  assign s_in_valid = drv_valid && sel_sat;
  assign drv_ready  = sel_sat ? s_in_ready : in_ready;

  pkt_rx_checker #(.DW(DW), .N_DATA(N), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_sop(drv_sop), .in_data(drv_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_src(out_src), .out_dst(out_dst), .out_crc_ok(out_crc_ok),
    .good_cnt(good_cnt), .bad_cnt(bad_cnt), .frame_err_cnt(frame_err_cnt)
  );

  pkt_rx_checker #(.DW(DW), .N_DATA(N), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_sop(drv_sop), .in_data(drv_data),
    .out_valid(s_out_valid), .out_ready(1'b1),
    .out_src(s_out_src), .out_dst(s_out_dst), .out_crc_ok(s_out_crc_ok),
    .good_cnt(s_good_cnt), .bad_cnt(s_bad_cnt), .frame_err_cnt(s_frame_err_cnt)
  );

  typedef struct packed {
    logic [DW-1:0] src;
    logic [DW-1:0] dst;
    logic          ok;
  } res_t;

  res_t          sb[$];
  int            checks = 0;
  int            errors = 0;
  int            exp_good = 0, exp_bad = 0, exp_frame = 0;
  logic [DW-1:0] data_buf [N];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: one comparison set per result handshake on the main instance.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got src=0x%0h dst=0x%0h, expected no result", out_src, out_dst);
      end else begin
        res_t e;
        e = sb.pop_front();
        check("res_src", out_src, e.src);
        check("res_dst", out_dst, e.dst);
        check("res_crc_ok", {31'd0, out_crc_ok}, {31'd0, e.ok});
        $display("result src=0x%0h dst=0x%0h crc_ok=%0d", out_src, out_dst, out_crc_ok);
      end
    end
  end

  task automatic send_word(input logic [DW-1:0] w, input logic sop);
    int t;
    t = 0;
    drv_data  = w;
    drv_sop   = sop;
    drv_valid = 1'b1;
    while (!drv_ready && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 100) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout: got in_ready=0 for 100 cycles, expected 1");
    end
    @(posedge clk); #1;
    drv_valid = 1'b0;
    drv_sop   = 1'b0;
  endtask

  function automatic logic [DW-1:0] crc_of(input logic [DW-1:0] s, input logic [DW-1:0] d);
    logic [DW-1:0] c;
    c = s ^ d;
    for (int i = 0; i < N; i++) c = c ^ data_buf[i];
    return c;
  endfunction

  task automatic fill(input logic [DW-1:0] base);
    for (int i = 0; i < N; i++) data_buf[i] = base + DW'(i);
  endtask

  // Sends a full packet from data_buf; checks out_valid one cycle after crc.
  task automatic send_packet(input logic [DW-1:0] s, input logic [DW-1:0] d,
                             input logic [DW-1:0] crc, input logic ok);
    if (!sel_sat) begin
      sb.push_back('{src: s, dst: d, ok: ok});
      if (ok) exp_good++;
      else exp_bad++;
    end
    $display("packet src=0x%0h dst=0x%0h crc=0x%0h", s, d, crc);
    send_word(s, 1'b1);
    send_word(d, 1'b0);
    for (int i = 0; i < N; i++) send_word(data_buf[i], 1'b0);
    send_word(crc, 1'b0);
    check("latency_out_valid", {31'd0, (sel_sat ? s_out_valid : out_valid)}, 32'd1);
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_good_cnt"}, {16'd0, good_cnt}, DW'(exp_good));
    check({tag, "_bad_cnt"}, {16'd0, bad_cnt}, DW'(exp_bad));
    check({tag, "_frame_err_cnt"}, {16'd0, frame_err_cnt}, DW'(exp_frame));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    exp_good  = 0;
    exp_bad   = 0;
    exp_frame = 0;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_src", out_src, 32'd0);
    check("rst_out_dst", out_dst, 32'd0);
    check("rst_out_crc_ok", {31'd0, out_crc_ok}, 32'd0);
    check_counters("rst");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish by 1ms, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    drv_valid = 1'b0;
    drv_sop   = 1'b0;
    drv_data  = '0;
    sel_sat   = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Good packet: data 0x10..0x17 XOR to 0, so crc = 0x1 ^ 0x2 = 0x3.
    fill(32'h10);
    send_packet(32'h1, 32'h2, 32'h3, 1'b1);
    check_counters("good");

    // Bad crc.
    send_packet(32'h1, 32'h2, 32'hFFFF_FFFC, 1'b0);
    check_counters("badcrc");

    // Backpressure: hold the result for 5 cycles.
    @(posedge clk); #1;
    out_ready = 1'b0;
    fill(32'h100);
    send_packet(32'hAAAA_0001, 32'hBBBB_0002, crc_of(32'hAAAA_0001, 32'hBBBB_0002), 1'b1);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_out_src", out_src, 32'hAAAA_0001);
      check("bp_out_dst", out_dst, 32'hBBBB_0002);
      check("bp_out_crc_ok", {31'd0, out_crc_ok}, 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_out_valid", {31'd0, out_valid}, 32'd0);
    check("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
    fill(32'h200);
    send_packet(32'h5, 32'h6, crc_of(32'h5, 32'h6), 1'b1);
    check_counters("bp");

    // Framing case 1: two stray words before a packet.
    send_word(32'h55, 1'b0);
    send_word(32'h66, 1'b0);
    exp_frame += 2;
    check_counters("frame1_stray");
    fill(32'h10);
    send_packet(32'h1, 32'h2, 32'h3, 1'b1);
    check_counters("frame1");

    // Framing case 2: sop on data word 4 aborts and starts a new packet.
    send_word(32'hA, 1'b1);
    send_word(32'hB, 1'b0);
    for (int i = 0; i < 4; i++) send_word(32'h40 + i, 1'b0);
    exp_frame++;
    fill(32'h30);
    // new packet: src 0x20, dst 0x21, data 0x30..0x37 (XOR 0) -> crc 0x01
    sb.push_back('{src: 32'h20, dst: 32'h21, ok: 1'b1});
    exp_good++;
    send_word(32'h20, 1'b1);
    send_word(32'h21, 1'b0);
    for (int i = 0; i < N; i++) send_word(data_buf[i], 1'b0);
    send_word(32'h1, 1'b0);
    check("abort_out_valid", {31'd0, out_valid}, 32'd1);
    check_counters("frame2");

    // Reset mid-S_DATA.
    @(posedge clk); #1;
    send_word(32'h7, 1'b1);
    send_word(32'h8, 1'b0);
    for (int i = 0; i < 3; i++) send_word(32'h90 + i, 1'b0);
    do_reset();
    fill(32'h10);
    send_packet(32'h1, 32'h2, 32'h3, 1'b1);
    check_counters("post_rst1");

    // Reset while a result is pending.
    @(posedge clk); #1;
    out_ready = 1'b0;
    send_packet(32'h1, 32'h2, 32'h3, 1'b1);
    @(posedge clk); #1;
    do_reset();
    out_ready = 1'b1;
    fill(32'h300);
    send_packet(32'hC0DE, 32'hBEEF, crc_of(32'hC0DE, 32'hBEEF), 1'b1);
    check_counters("post_rst2");

    // Saturation on the CNT_W=2 instance: 5 bad packets, bad_cnt stops at 3.
    @(posedge clk); #1;
    sel_sat = 1'b1;
    fill(32'h10);
    for (int p = 0; p < 5; p++) begin
      send_packet(32'h1, 32'h2, 32'hFFFF_FFFC, 1'b0);
      check("sat_crc_ok", {31'd0, s_out_crc_ok}, 32'd0);
      check("sat_bad_cnt", {30'd0, s_bad_cnt}, (p + 1 > 3) ? 32'd3 : DW'(p + 1));
      check("sat_good_cnt", {30'd0, s_good_cnt}, 32'd0);
    end
    sel_sat = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", DW'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
